// File: rtl/keyboard_fifo_wb.sv
// Keyboard STATUS/DATA register pair with a key FIFO, typematic autorepeat and
// vector-60/274 interrupt requests, all running on clk_bus.
module keyboard_fifo_wb #(
    parameter logic [15:0] BASE_ADDR    = 16'o177660,
    parameter int          DEPTH_LOG2   = 3,
    parameter logic [23:0] DELAY_CYCLES = 24'd12_000_000,
    parameter logic [23:0] RATE_CYCLES  = 24'd2_400_000
) (
    input  logic        clk_bus,
    input  logic        bus_reset_n,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_addr,
    input  logic        bus_sync,
    input  logic        bus_we,
    input  logic        bus_stb,
    input  logic [1:0]  bus_wtbt,
    output logic        bus_ack,
    input  logic        key_valid,
    input  logic [6:0]  key_code,
    input  logic        key_alt,
    input  logic        key_held,
    output logic        virq_req60,
    output logic        virq_req274,
    input  logic        virq_ack60,
    input  logic        virq_ack274
);
    // state    | meaning
    // S_IDLE   | no autorepeat in progress
    // S_DELAY  | key held, counting down to the first repeat
    // S_REPEAT | key held, counting down between repeats
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam int          CW      = DEPTH_LOG2 + 1;
    localparam logic [15:0] DT_ADDR = BASE_ADDR + 16'd2;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [15:0]           r_data_o;
    logic                  r_ack_q, r_acc_st_q, r_acc_dt_q;
    logic                  r_mask, r_rpt_en, r_ovf, r_armed;
    logic                  r_req60, r_req274, r_ack60_q, r_ack274_q;
    logic [7:0]            r_rpt_entry;
    state_t                r_state, w_state_nxt;
    logic [23:0]           r_cnt, w_cnt_nxt;

    logic w_sel_st, w_sel_dt, w_acc_st, w_acc_dt;
    logic w_wr_st, w_rd_st, w_rd_dt;
    logic w_empty, w_full, w_pop, w_push, w_drop, w_push_req, w_key_ok, w_rpt_evt, w_arm;
    logic w_fire, w_ack60_rise, w_ack274_rise;
    logic [7:0]    w_push_data, w_head;
    logic [CW-1:0] w_count_nxt;
    logic [15:0]   w_status;
    logic          w_unused;

    assign w_unused = ^{bus_wtbt, bus_din[15:10], bus_din[7], bus_din[5:0]};

    assign w_sel_st = bus_sync & (bus_addr[15:1] == BASE_ADDR[15:1]);
    assign w_sel_dt = bus_sync & (bus_addr[15:1] == DT_ADDR[15:1]) & ~bus_we;
    assign w_acc_st = bus_stb & w_sel_st;
    assign w_acc_dt = bus_stb & w_sel_dt;
    assign w_wr_st  = w_acc_st & ~r_acc_st_q & bus_we;
    assign w_rd_st  = w_acc_st & ~r_acc_st_q & ~bus_we;
    assign w_rd_dt  = w_acc_dt & ~r_acc_dt_q;

    assign bus_ack  = bus_stb & (w_sel_st | w_sel_dt) & r_ack_q;
    assign bus_dout = (w_sel_st | w_sel_dt) ? r_data_o : 16'd0;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_pop       = w_rd_dt & ~w_empty;
    assign w_key_ok    = key_valid & (key_code != 7'd0);
    assign w_push_req  = w_key_ok | w_rpt_evt;
    assign w_push_data = w_key_ok ? {key_alt, key_code} : r_rpt_entry;
    // A same-cycle pop frees a slot before the push is considered.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_arm       = (w_push & w_empty) | (w_pop & (w_count_nxt != '0));

    assign w_status = {6'd0, r_rpt_en, r_ovf, ~w_empty, r_mask, 6'(r_count)};

    assign w_fire        = r_armed & ~r_mask;
    assign w_ack60_rise  = virq_ack60 & ~r_ack60_q;
    assign w_ack274_rise = virq_ack274 & ~r_ack274_q;
    assign virq_req60    = r_req60;
    assign virq_req274   = r_req274;

    always_ff @(posedge clk_bus) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk_bus or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_o    <= 16'd0;
            r_ack_q     <= 1'b0;
            r_acc_st_q  <= 1'b0;
            r_acc_dt_q  <= 1'b0;
            r_mask      <= 1'b1;
            r_rpt_en    <= 1'b1;
            r_ovf       <= 1'b0;
            r_armed     <= 1'b0;
            r_req60     <= 1'b0;
            r_req274    <= 1'b0;
            r_ack60_q   <= 1'b0;
            r_ack274_q  <= 1'b0;
            r_rpt_entry <= 8'd0;
        end else begin
            r_ack_q    <= bus_stb;
            r_acc_st_q <= w_acc_st;
            r_acc_dt_q <= w_acc_dt;
            r_ack60_q  <= virq_ack60;
            r_ack274_q <= virq_ack274;
            r_count    <= w_count_nxt;
            r_armed    <= w_arm;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_key_ok) r_rpt_entry <= {key_alt, key_code};
            if (w_rd_st)    r_data_o <= w_status;
            else if (w_pop) r_data_o <= {9'd0, w_head[6:0]};
            if (w_wr_st) begin
                r_mask   <= bus_din[6];
                r_rpt_en <= bus_din[9];
            end
            if (w_drop)                   r_ovf <= 1'b1;
            else if (w_wr_st & bus_din[8]) r_ovf <= 1'b0;
            // A DATA read retires the head, so it also retires any request for it.
            if (w_rd_dt)                 r_req60 <= 1'b0;
            else if (w_fire & ~w_head[7]) r_req60 <= 1'b1;
            else if (w_ack60_rise)       r_req60 <= 1'b0;
            if (w_rd_dt)                 r_req274 <= 1'b0;
            else if (w_fire & w_head[7]) r_req274 <= 1'b1;
            else if (w_ack274_rise)      r_req274 <= 1'b0;
        end
    end

    always_ff @(posedge clk_bus or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 24'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rpt_evt   = 1'b0;
        if (!key_held || !r_rpt_en) begin
            w_state_nxt = S_IDLE;
        end else if (w_key_ok) begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = DELAY_CYCLES - 24'd1;
        end else if (r_state != S_IDLE) begin
            if (r_cnt == 24'd0) begin
                w_rpt_evt   = 1'b1;
                w_cnt_nxt   = RATE_CYCLES - 24'd1;
                w_state_nxt = S_REPEAT;
            end else begin
                w_cnt_nxt = r_cnt - 24'd1;
            end
        end
    end
endmodule
